lsu_sram_ctrl: RTL and testbench
================================

// Module: lsu_sram_ctrl
// PURPOSE
//  Load/store front-end for the 4 KB word-organised data SRAM (1024 x 32, 1-cycle registered read).
//  - Accepts CPU byte/half/word load and store requests over a valid/ready handshake.
//  - Checks alignment and address window, then drives the SRAM address, write data and byte-enable lanes.
//  - Returns sign- or zero-extended load data, or a store acknowledge, over a valid/ready response channel.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte base of SRAM window; must be 4 KB aligned
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  req_valid  in   1   request valid
//  req_ready  out  1   request accepted when req_valid & req_ready
//  req_we     in   1   1=store, 0=load
//  req_addr   in   32  byte address
//  req_size   in   2   00=byte, 01=half, 10=word, 11=illegal
//  req_uns    in   1   load zero-extend (1) / sign-extend (0); ignored for stores
//  req_wdata  in   32  store data, right-justified
//  resp_valid out  1   response valid; held until resp_ready
//  resp_ready in   1   response consumed when resp_valid & resp_ready
//  resp_rdata out  32  extended load data; 0 for stores and errors
//  resp_err   out  1   misaligned, illegal size, or address outside the window
//  mem_a      out  10  SRAM word address = req_addr[11:2]
//  mem_wd     out  32  SRAM write data, lane-shifted
//  mem_wen    out  4   SRAM byte write enables; 0000 = read
//  mem_cs     out  1   SRAM chip select
//  mem_rd     in   32  SRAM read data, valid the cycle after a read access
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rst_n).
//  - Reset: state=IDLE. req_ready=1 once reset is released. resp_valid, resp_err, mem_cs = 0.
//    mem_wen, mem_a, mem_wd, resp_rdata = 0.
//  - FSM states:
//    - IDLE: req_ready=1. On accept: latch the request, go to ACCESS.
//    - ACCESS: one cycle. mem_cs = ~err_q. mem_wen = (we_q & ~err_q) ? mask_q : 4'b0000. Go to RESP.
//    - RESP: resp_valid=1.
//      - If resp_ready & req_valid: accept the new request, go to ACCESS (back-to-back).
//      - Else if resp_ready: go to IDLE.
//      - Else: stay in RESP, all outputs stable.
//  - req_ready = IDLE | (RESP & resp_ready). The combinational path resp_ready -> req_ready is allowed.
//  - Latency: accept at edge N. SRAM access in cycle N..N+1. resp_valid from cycle N+2.
//    Peak throughput is one request per 2 cycles.
//  - Latch-time decode:
//    - off = req_addr[1:0].
//    - mask: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
//    - wd_q = req_wdata << (8*off).
//    - err = (size==11) | (half & off[0]) | (word & off!=0) | (req_addr[31:12] != BASE_ADDR[31:12]).
//  - Error requests: no SRAM access (mem_cs=0 in ACCESS). Same latency. resp_err=1, resp_rdata=0.
//  - Load data:
//    - resp_rdata = extend(mem_rd >> (8*off_q), size_q, uns_q), combinational in RESP.
//    - mem_rd stays stable during RESP because no access is issued while in RESP.
//  - Stores: resp_rdata=0, resp_err=0. Only the enabled lanes change in the SRAM.
//  - mem_* are decoded from state/latched registers only. When not in ACCESS: mem_cs=0 and mem_wen=0.
//  - Request fields must be stable only in the accept cycle.
//  - Reset mid-operation: state clears asynchronously, so mem_cs falls at once.
//    No SRAM write happens at any edge while rst_n=0. Any pending response is dropped.
// STRUCTURE
//  - Package lsu_pkg:
//    - size encodings: SZ_B, SZ_H, SZ_W.
//    - state enum: IDLE, ACCESS, RESP.
//    - function byte_mask(size, off).
//  - Sub-module lsu_load_align (combinational): mem_rd, off, size, uns -> 32-bit extended data.
//  - Everything else stays in this module.
// TESTING
//  1. Store word 32'hDEADBEEF @0x10, then load word @0x10:
//     - store ACCESS shows mem_a=4, mem_wen=1111, mem_cs=1.
//     - load returns 32'hDEADBEEF, err=0, resp_valid 2 cycles after accept.
//  2. Store byte 8'h80 @0x13 over word 0, then read back:
//     - store shows mem_wen=1000, mem_wd=32'h8000_0000.
//     - lb @0x13 returns 32'hFFFF_FF80; lbu @0x13 returns 32'h0000_0080.
//  3. lh @0x12 on word 32'h8001_0000 -> 32'hFFFF_8001.
//     lhu @0x11 -> resp_err=1, rdata=0, mem_cs never asserted.
//  4. Hold resp_ready=0 for 5 cycles:
//     - resp_valid, resp_rdata, resp_err stay stable; req_ready=0; no mem_cs pulse.
//  5. resp_ready=1 with continuous req_valid:
//     - mem_cs pulses every 2nd cycle; responses arrive in order.
//     - Address 0x1000 (outside window) -> err=1.
//  6. Drop rst_n during ACCESS of a store word 32'h1234_5678 @0x20:
//     - mem_cs falls at once; resp_valid=0.
//     - After release, lw @0x20 returns the old value.

Source files
------------

// File: rtl/lsu_sram_ctrl_pkg.sv
// rtl/lsu_sram_ctrl_pkg.sv - shared encodings, FSM states and lane-mask helper for the LSU
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sram_ctrl_if.sv
// rtl/lsu_sram_ctrl_if.sv - CPU-side request/response channel of the LSU
interface lsu_sram_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_uns, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_uns, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_sram_ctrl_load_align.sv
// rtl/lsu_sram_ctrl_load_align.sv - shifts SRAM read word down by byte offset and extends
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = mem_rd >> {off, 3'b000};
    case (size)
      SZ_B:    data = {{24{~uns & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// rtl/lsu_sram_ctrl.sv - load/store front-end for the 1024x32 data SRAM
module lsu_sram_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_sram_ctrl_if.slave    bus,
  output logic [9:0]        mem_a,
  output logic [31:0]       mem_wd,
  output logic [3:0]        mem_wen,
  output logic              mem_cs,
  input  logic [31:0]       mem_rd
);

  state_e      state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  off_q, size_q;
  logic [3:0]  mask_q;
  logic [9:0]  a_q;
  logic [31:0] wd_q;

  logic        accept;
  logic        req_err;
  logic [1:0]  req_off;
  logic [31:0] load_data;

  assign req_off = bus.req_addr[1:0];
  assign accept  = bus.req_valid & bus.req_ready;

  always_comb begin
    req_err = (bus.req_size == 2'b11)
            | ((bus.req_size == SZ_H) & req_off[0])
            | ((bus.req_size == SZ_W) & (req_off != 2'b00))
            | (bus.req_addr[31:12] != BASE_ADDR[31:12]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      mask_q  <= 4'b0000;
      a_q     <= 10'd0;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q   <= bus.req_we;
        uns_q  <= bus.req_uns;
        err_q  <= req_err;
        off_q  <= req_off;
        size_q <= bus.req_size;
        mask_q <= byte_mask(bus.req_size, req_off);
        a_q    <= bus.req_addr[11:2];
        wd_q   <= bus.req_wdata << {req_off, 3'b000};
      end
    end
  end

  // resp_ready feeds req_ready combinationally so RESP can hand over straight to ACCESS
  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    mem_cs         = 1'b0;
    mem_wen        = 4'b0000;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        mem_cs  = ~err_q;
        mem_wen = (we_q & ~err_q) ? mask_q : 4'b0000;
        state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.req_ready  = bus.resp_ready;
        if (bus.resp_ready) state_d = bus.req_valid ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .mem_rd (mem_rd),
    .off    (off_q),
    .size   (size_q),
    .uns    (uns_q),
    .data   (load_data)
  );

  assign mem_a          = a_q;
  assign mem_wd         = wd_q;
  assign bus.resp_err   = (state_q == RESP) & err_q;
  assign bus.resp_rdata = ((state_q == RESP) & ~we_q & ~err_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// tb/tb_lsu_sram_ctrl.sv - directed scoreboard bench for lsu_sram_ctrl
module tb_lsu_sram_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  mem_a;
  logic [31:0] mem_wd;
  logic [3:0]  mem_wen;
  logic        mem_cs;
  logic [31:0] mem_rd = 32'd0;
  logic [31:0] sram [0:1023];

  logic [32:0] sb [$];
  logic [32:0] mon_e;
  int          passed = 0;
  int          total = 0;
  int          w;

  always #5 clk = ~clk;

  lsu_sram_ctrl_if bus();

  lsu_sram_ctrl #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .mem_a   (mem_a),
    .mem_wd  (mem_wd),
    .mem_wen (mem_wen),
    .mem_cs  (mem_cs),
    .mem_rd  (mem_rd)
  );

  always @(posedge clk) begin
    if (mem_cs) begin
      for (int i = 0; i < 4; i++)
        if (mem_wen[i]) sram[mem_a][8*i +: 8] <= mem_wd[8*i +: 8];
      if (mem_wen == 4'b0000) mem_rd <= sram[mem_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Responses complete on the next rising edge; sample them on the falling edge before it.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, mon_e[31:0]);
        chk1("resp_err", bus.resp_err, mon_e[32]);
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, output int waited);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_uns   = uns;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) chk("accept_timeout", 32'd20, 32'd0);
    chk1("ready_cs", mem_cs, 1'b0);
    sb.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_size   = SZ_W;
    bus.req_uns    = 1'b0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) sram[i] = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_cs", mem_cs, 1'b0);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_resp_err", bus.resp_err, 1'b0);
    chk("rst_wen", {28'd0, mem_wen}, 32'd0);
    chk("rst_mem_a", {22'd0, mem_a}, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);

    // 1: word store then load
    do_req(1'b1, 32'h10, SZ_W, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, w);
    chk("t1_mem_a", {22'd0, mem_a}, 32'd4);
    chk("t1_wen", {28'd0, mem_wen}, 32'hF);
    chk1("t1_cs", mem_cs, 1'b1);
    drain();
    do_req(1'b0, 32'h10, SZ_W, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, w);
    chk1("t1_rd_cs", mem_cs, 1'b1);
    chk("t1_rd_wen", {28'd0, mem_wen}, 32'd0);
    chk1("t1_lat_n1", bus.resp_valid, 1'b0);
    @(posedge clk); #1;
    chk1("t1_lat_n2", bus.resp_valid, 1'b1);
    drain();

    // 2: byte store into a zero word, signed and unsigned byte loads
    do_req(1'b1, 32'h10, SZ_W, 1'b0, 32'd0, 32'd0, 1'b0, w);
    drain();
    do_req(1'b1, 32'h13, SZ_B, 1'b0, 32'h80, 32'd0, 1'b0, w);
    chk("t2_wen", {28'd0, mem_wen}, 32'h8);
    chk("t2_wd", mem_wd, 32'h8000_0000);
    drain();
    do_req(1'b0, 32'h13, SZ_B, 1'b0, 32'd0, 32'hFFFF_FF80, 1'b0, w);
    drain();
    do_req(1'b0, 32'h13, SZ_B, 1'b1, 32'd0, 32'h0000_0080, 1'b0, w);
    drain();

    // 3: signed half load, misaligned half load
    do_req(1'b1, 32'h10, SZ_W, 1'b0, 32'h8001_0000, 32'd0, 1'b0, w);
    drain();
    do_req(1'b0, 32'h12, SZ_H, 1'b0, 32'd0, 32'hFFFF_8001, 1'b0, w);
    drain();
    do_req(1'b0, 32'h11, SZ_H, 1'b1, 32'd0, 32'd0, 1'b1, w);
    chk1("t3_err_cs_access", mem_cs, 1'b0);
    @(posedge clk); #1;
    chk1("t3_err_cs_resp", mem_cs, 1'b0);
    drain();

    // 4: response back-pressure
    do_req(1'b1, 32'h40, SZ_W, 1'b0, 32'h5A5A_A5A5, 32'd0, 1'b0, w);
    drain();
    do_req(1'b0, 32'h40, SZ_W, 1'b0, 32'd0, 32'h5A5A_A5A5, 1'b0, w);
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk1("t4_valid", bus.resp_valid, 1'b1);
      chk("t4_rdata", bus.resp_rdata, 32'h5A5A_A5A5);
      chk1("t4_err", bus.resp_err, 1'b0);
      chk1("t4_req_ready", bus.req_ready, 1'b0);
      chk1("t4_cs", mem_cs, 1'b0);
    end
    bus.resp_ready = 1'b1;
    drain();

    // 5: continuous requests, one every two cycles, including an out-of-window access
    do_req(1'b1, 32'h4, SZ_W, 1'b0, 32'h1111_2222, 32'd0, 1'b0, w);
    chk1("t5_cs0", mem_cs, 1'b1);
    do_req(1'b0, 32'h4, SZ_W, 1'b0, 32'd0, 32'h1111_2222, 1'b0, w);
    chk("t5_gap1", w, 32'd1);
    chk1("t5_cs1", mem_cs, 1'b1);
    do_req(1'b0, 32'h1000, SZ_W, 1'b0, 32'd0, 32'd0, 1'b1, w);
    chk("t5_gap2", w, 32'd1);
    chk1("t5_cs2", mem_cs, 1'b0);
    do_req(1'b0, 32'h6, SZ_H, 1'b1, 32'd0, 32'h0000_1111, 1'b0, w);
    chk("t5_gap3", w, 32'd1);
    chk1("t5_cs3", mem_cs, 1'b1);
    drain();

    // 6: reset during a store access leaves the SRAM untouched
    do_req(1'b1, 32'h20, SZ_W, 1'b0, 32'hCAFE_F00D, 32'd0, 1'b0, w);
    drain();
    do_req(1'b1, 32'h20, SZ_W, 1'b0, 32'h1234_5678, 32'd0, 1'b0, w);
    chk1("t6_cs_before", mem_cs, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t6_cs_reset", mem_cs, 1'b0);
    chk1("t6_valid_reset", bus.resp_valid, 1'b0);
    chk("t6_wen_reset", {28'd0, mem_wen}, 32'd0);
    void'(sb.pop_back());
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h20, SZ_W, 1'b0, 32'd0, 32'hCAFE_F00D, 1'b0, w);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
